// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, {CPOL,CPHA} mode constants and
// the sample-edge selector used by the slave and the one-character master.
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Modes are written as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // 1 when data is sampled on the rising SCK edge, 0 when on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    logic [1:0] m;
    m = {cpol, cpha};
    case (m)
      MODE0, MODE3: return 1'b1;
      MODE1, MODE2: return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the last two registered samples.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Pulses are built only from flops, so they are one sysclk wide and glitch-free.
  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_char.sv
// SPI slave character engine running on S_SYSCLK with oversampled pins,
// a transmit holding register (valid/ready) and a receive register (valid/ack).
module spi_slave_char #(
  parameter  int CHAR_NBITS  = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(CHAR_NBITS)
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic                  S_TX_ONLY,
  input  logic [LW-1:0]         S_CHAR_LEN,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_CS_N,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  output logic                  S_SPI_MISO_OE,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  input  logic                  S_WCHAR_VALID,
  output logic                  S_WCHAR_READY,
  output logic [CHAR_NBITS-1:0] S_RCHAR,
  output logic                  S_RCHAR_VALID,
  input  logic                  S_RCHAR_ACK,
  output logic                  S_OVERRUN,
  output logic                  S_UNDERRUN,
  output logic [1:0]            o_dbg_state
);
  import spi_pkg::*;

  // Handshakes: a transmit word moves into the holding register on a cycle where
  // S_WCHAR_VALID && S_WCHAR_READY; S_RCHAR_VALID stays high until S_RCHAR_ACK.
  logic w_sck_rise, w_sck_fall, w_sck;
  logic w_cs_n, w_cs_fall;
  logic w_mosi;
  logic w_unused_cs_rise, w_unused_sck;
  logic [1:0] w_unused_mosi_edges;
  logic w_sample, w_shift, w_wr;
  logic [LW-1:0] w_rx_idx;

  logic [1:0]            r_state;
  logic [CHAR_NBITS-1:0] r_sr, r_rx, r_hold, r_rchar;
  logic [LW-1:0]         r_cnt;
  logic r_hold_full, r_und_pend, r_en_q, r_rvalid, r_ovr, r_und;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(S_SYSCLK), .i_rst_n(S_RESETN), .i_d(S_SPI_SCK),
    .o_q(w_unused_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(S_SYSCLK), .i_rst_n(S_RESETN), .i_d(S_SPI_CS_N),
    .o_q(w_cs_n), .o_rise(w_unused_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(S_SYSCLK), .i_rst_n(S_RESETN), .i_d(S_SPI_MOSI),
    .o_q(w_mosi), .o_rise(w_unused_mosi_edges[0]), .o_fall(w_unused_mosi_edges[1])
  );

  assign w_sck    = sample_on_rise(S_CPOL, S_CPHA);
  assign w_sample = w_sck ? w_sck_rise : w_sck_fall;
  assign w_shift  = w_sck ? w_sck_fall : w_sck_rise;
  assign w_rx_idx = S_REV ? (S_CHAR_LEN - r_cnt) : r_cnt;
  assign w_wr     = S_WCHAR_VALID & S_WCHAR_READY;

  assign S_WCHAR_READY = S_ENABLE & r_en_q & ~r_hold_full;
  assign S_SPI_MISO    = (r_state == ST_IDLE) ? 1'b1 : (S_REV ? r_sr[S_CHAR_LEN] : r_sr[0]);
  assign S_SPI_MISO_OE = (r_state != ST_IDLE);
  assign S_RCHAR       = r_rchar;
  assign S_RCHAR_VALID = r_rvalid;
  assign S_OVERRUN     = r_ovr;
  assign S_UNDERRUN    = r_und;
  assign o_dbg_state   = r_state;

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_rx        <= '0;
      r_hold      <= '0;
      r_rchar     <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
      r_und_pend  <= 1'b0;
      r_en_q      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_ovr       <= 1'b0;
      r_und       <= 1'b0;
    end else begin
      r_en_q <= S_ENABLE;
      if (w_wr) begin
        r_hold      <= S_WCHAR;
        r_hold_full <= 1'b1;
      end
      if (r_state == ST_DONE && !S_TX_ONLY) begin
        r_rchar  <= r_rx;
        r_rvalid <= 1'b1;
        if (r_rvalid && !S_RCHAR_ACK) r_ovr <= 1'b1;
      end else if (S_RCHAR_ACK) begin
        r_rvalid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: if (w_cs_fall) r_state <= ST_LOAD;
        ST_LOAD: begin
          // Underrun is only committed once a bit of the character is clocked,
          // so the reload after a final character (CS about to rise) is silent.
          if (r_hold_full) begin
            r_sr        <= r_hold;
            r_hold_full <= 1'b0;
            r_und_pend  <= 1'b0;
          end else begin
            r_sr       <= '1;
            r_und_pend <= 1'b1;
          end
          r_cnt   <= '0;
          r_rx    <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_sample) begin
            r_rx[w_rx_idx] <= w_mosi;
            if (r_und_pend) begin
              r_und      <= 1'b1;
              r_und_pend <= 1'b0;
            end
            if (r_cnt == S_CHAR_LEN) r_state <= ST_DONE;
            else                     r_cnt   <= r_cnt + LW'(1);
          end else if (w_shift && r_cnt != '0) begin
            // The shift edge before the first sample (or after the last) moves nothing.
            r_sr <= S_REV ? (r_sr << 1) : (r_sr >> 1);
          end
        end
        default: r_state <= ST_LOAD;
      endcase
      if (w_cs_n || !S_ENABLE) r_state <= ST_IDLE;
      if (!S_ENABLE) begin
        r_hold_full <= 1'b0;
        r_und_pend  <= 1'b0;
        r_ovr       <= 1'b0;
        r_und       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_char.sv
// Bench for spi_slave_char: an SPI master driver, a fabric-side preload and
// ack agent, and a scoreboard of expected received characters.
module tb_spi_slave_char;
  import spi_pkg::*;

  localparam int HP = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, cpol, cpha, rev, tx_only;
  logic [3:0] char_len;
  logic sck, cs_n, mosi, miso, miso_oe;
  logic [15:0] wchar, rchar;
  logic wvalid, wready, rvalid, ack, ovr, und;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic ack_en;
  logic [15:0] tx_w[4];
  logic [15:0] rd_w[4];

  always #5 clk = ~clk;

  spi_slave_char dut (
    .S_SYSCLK(clk), .S_RESETN(rst_n), .S_ENABLE(enable),
    .S_CPOL(cpol), .S_CPHA(cpha), .S_REV(rev), .S_TX_ONLY(tx_only),
    .S_CHAR_LEN(char_len),
    .S_SPI_SCK(sck), .S_SPI_CS_N(cs_n), .S_SPI_MOSI(mosi),
    .S_SPI_MISO(miso), .S_SPI_MISO_OE(miso_oe),
    .S_WCHAR(wchar), .S_WCHAR_VALID(wvalid), .S_WCHAR_READY(wready),
    .S_RCHAR(rchar), .S_RCHAR_VALID(rvalid), .S_RCHAR_ACK(ack),
    .S_OVERRUN(ovr), .S_UNDERRUN(und), .o_dbg_state(dbg_state)
  );

  // Fabric receive agent: acks each valid character and logs it.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && rvalid && !ack) begin
        got_q.push_back(rchar);
        ack = 1'b1;
      end else begin
        ack = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mask(input int nb);
    logic [16:0] m;
    m = (17'd1 << nb) - 17'd1;
    return m[15:0];
  endfunction

  task automatic set_mode(input logic [1:0] m, input logic r, input logic [3:0] l);
    {cpol, cpha} = m;
    rev = r;
    char_len = l;
    sck = m[1];
    cyc(8);
  endtask

  task automatic clear_flags();
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(2);
  endtask

  task automatic preload(input logic [15:0] d);
    int t;
    t = 0;
    while (!wready && t < 400) begin
      cyc(1);
      t++;
    end
    check("wready", wready, 1);
    if (wready) begin
      wchar  = d;
      wvalid = 1'b1;
      cyc(1);
      wvalid = 1'b0;
    end
  endtask

  // One character as a master; bit i of the wire order maps to data position pos.
  task automatic spi_char(input logic [15:0] w, input int nb, output logic [15:0] r);
    int pos;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      pos = rev ? (nb - 1 - i) : i;
      if (!cpha) begin
        mosi = w[pos];
        cyc(HP);
        r[pos] = miso;
        sck = ~cpol;
        cyc(HP);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = w[pos];
        cyc(HP);
        r[pos] = miso;
        sck = cpol;
        cyc(HP);
      end
    end
  endtask

  task automatic spi_frame(input int nchar);
    logic [15:0] r;
    cs_n = 1'b0;
    cyc(HP);
    for (int i = 0; i < nchar; i++) begin
      spi_char(tx_w[i], int'(char_len) + 1, r);
      rd_w[i] = r;
    end
    cyc(HP);
    cs_n = 1'b1;
    cyc(2 * HP);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] tmp, d, pv, mk;
    logic [1:0] m;
    logic r, pre, txo;
    logic [3:0] l;

    rst_n = 1'b0; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; rev = 1'b1; tx_only = 1'b0;
    char_len = 4'd7; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; wchar = '0; wvalid = 1'b0;
    ack_en = 1'b1;
    cyc(3);
    check("rst_miso", miso, 1);
    check("rst_oe", miso_oe, 0);
    check("rst_ready", wready, 0);
    check("rst_rchar", rchar, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ovr", ovr, 0);
    check("rst_und", und, 0);
    rst_n = 1'b1;
    cyc(2);
    check("ready_disabled", wready, 0);
    enable = 1'b1;
    cyc(1);
    check("ready_after_enable", wready, 1);

    // Mode 3, MSB first, 8 bits.
    clear_flags();
    set_mode(MODE3, 1'b1, 4'd7);
    preload(16'h005A);
    tx_w[0] = 16'h00AA; exp_q.push_back(16'h00AA);
    spi_frame(1);
    check("m3_miso", rd_w[0], 16'h005A);
    drain("m3_rx");

    // Mode 0, LSB first, 16 bits.
    clear_flags();
    set_mode(MODE0, 1'b0, 4'd15);
    preload(16'h1234);
    tx_w[0] = 16'h55AA; exp_q.push_back(16'h55AA);
    spi_frame(1);
    check("m0_miso", rd_w[0], 16'h1234);
    drain("m0_rx");

    // Three back-to-back characters under one CS, modes 1 and 2.
    for (int k = 0; k < 2; k++) begin
      clear_flags();
      set_mode((k == 0) ? MODE1 : MODE2, 1'b1, 4'd7);
      preload(16'h0001);
      tx_w[0] = 16'h00A1; tx_w[1] = 16'h00B2; tx_w[2] = 16'h00C3;
      for (int i = 0; i < 3; i++) exp_q.push_back(tx_w[i]);
      fork
        spi_frame(3);
        begin
          preload(16'h0002);
          preload(16'h0003);
        end
      join
      for (int i = 0; i < 3; i++) check("b2b_miso", rd_w[i], 16'(i + 1));
      check("b2b_und", und, 0);
      check("b2b_ovr", ovr, 0);
      drain("b2b_rx");
    end

    // Overrun: second character completes without an ack.
    clear_flags();
    set_mode(MODE0, 1'b1, 4'd7);
    ack_en = 1'b0;
    preload(16'h0077);
    tx_w[0] = 16'h0011; tx_w[1] = 16'h0022;
    spi_frame(2);
    check("ovr_set", ovr, 1);
    check("ovr_rchar", rchar, 16'h0022);
    check("ovr_rvalid", rvalid, 1);
    clear_flags();
    check("ovr_cleared", ovr, 0);
    ack_en = 1'b1;
    cyc(4);
    check("ovr_acked", rvalid, 0);
    exp_q.push_back(16'h0022);
    drain("ovr_rx");

    // Underrun: nothing preloaded.
    clear_flags();
    set_mode(MODE0, 1'b1, 4'd7);
    tx_w[0] = 16'h0081; exp_q.push_back(16'h0081);
    spi_frame(1);
    check("und_miso", rd_w[0], 16'h00FF);
    check("und_set", und, 1);
    drain("und_rx");

    // CS raised after 4 of 8 bits, then a full character.
    clear_flags();
    set_mode(MODE0, 1'b1, 4'd7);
    preload(16'h0099);
    cs_n = 1'b0;
    cyc(HP);
    spi_char(16'h00F0, 4, tmp);
    cyc(HP);
    cs_n = 1'b1;
    cyc(2 * HP);
    check("abort_novalid", got_q.size(), 0);
    check("abort_und", und, 0);
    check("abort_ovr", ovr, 0);
    preload(16'h0066);
    tx_w[0] = 16'h003C; exp_q.push_back(16'h003C);
    spi_frame(1);
    check("abort_next_miso", rd_w[0], 16'h0066);
    drain("abort_rx");

    // Randomised single characters against the reference rules.
    for (int it = 0; it < 12; it++) begin
      m   = 2'($urandom_range(0, 3));
      r   = 1'($urandom_range(0, 1));
      l   = 4'($urandom_range(0, 15));
      mk  = mask(int'(l) + 1);
      d   = 16'($urandom) & mk;
      pv  = 16'($urandom);
      pre = ($urandom_range(0, 3) != 0);
      txo = ($urandom_range(0, 3) == 0);
      clear_flags();
      tx_only = txo;
      set_mode(m, r, l);
      if (pre) preload(pv);
      tx_w[0] = d;
      if (!txo) exp_q.push_back(d);
      spi_frame(1);
      check("rnd_miso", rd_w[0], pre ? (pv & mk) : mk);
      check("rnd_und", und, !pre);
      drain("rnd_rx");
      tx_only = 1'b0;
    end

    // Reset asserted in the middle of a character.
    clear_flags();
    set_mode(MODE0, 1'b1, 4'd7);
    ack_en = 1'b0;
    preload(16'h005A);
    cs_n = 1'b0;
    cyc(HP);
    spi_char(16'h00C5, 8, tmp);
    spi_char(16'h000F, 3, tmp);
    cyc(2);
    check("pre_rst_oe", miso_oe, 1);
    check("pre_rst_rvalid", rvalid, 1);
    check("pre_rst_rchar", rchar, 16'h00C5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_miso", miso, 1);
    check("mid_rst_oe", miso_oe, 0);
    check("mid_rst_ready", wready, 0);
    check("mid_rst_rchar", rchar, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_und", und, 0);
    cs_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
